// File: rtl/ti_sbox_sched_if.sv
// Request/grant, mask and S-box control bundle of the shared TI S-box scheduler.
// slave: scheduler side. master: requester / S-box side.
interface ti_sbox_sched_if #(
  parameter int unsigned LAT  = 4,
  parameter int unsigned IDXW = 4
);
  logic            StReqxSI;
  logic            StAckxSO;
  logic            KsReqxSI;
  logic            KsAckxSO;
  logic            RandValidxSI;
  logic            RandReqxSO;
  logic            InSelxSO;
  logic [IDXW-1:0] InIdxxDO;
  logic            InValidxSO;
  logic [LAT-1:0]  StageEnxSO;
  logic            OutValidxSO;
  logic            OutSelxSO;
  logic [IDXW-1:0] OutIdxxDO;
  logic            StDonexSO;
  logic            KsDonexSO;
  logic            BusyxSO;

  modport slave (
    input  StReqxSI, KsReqxSI, RandValidxSI,
    output StAckxSO, KsAckxSO, RandReqxSO, InSelxSO, InIdxxDO, InValidxSO,
           StageEnxSO, OutValidxSO, OutSelxSO, OutIdxxDO, StDonexSO, KsDonexSO,
           BusyxSO
  );

  modport master (
    output StReqxSI, KsReqxSI, RandValidxSI,
    input  StAckxSO, KsAckxSO, RandReqxSO, InSelxSO, InIdxxDO, InValidxSO,
           StageEnxSO, OutValidxSO, OutSelxSO, OutIdxxDO, StDonexSO, KsDonexSO,
           BusyxSO
  );
endinterface

// File: rtl/ti_sbox_sched.sv
// Scheduler sharing one pipelined TI S-box between the state datapath (16-byte
// bursts) and the key schedule (4-byte bursts). One burst in flight at a time;
// a tag pipeline shadows the S-box stages to route each result back.
// Optional feature macro: TI_SBOX_DUMMY_EN -- when defined, the S-box keeps
// clocking dummy masked data while idle whenever fresh masks are available.
module ti_sbox_sched #(
  parameter int unsigned LAT      = 4,
  parameter int unsigned ST_BYTES = 16,
  parameter int unsigned KS_BYTES = 4,
  parameter int unsigned IDXW     = 4
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  ti_sbox_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [IDXW-1:0] ST_LAST = IDXW'(ST_BYTES - 1);
  localparam logic [IDXW-1:0] KS_LAST = IDXW'(KS_BYTES - 1);

  state_t          r_state;
  logic            r_sel;
  logic            r_last_ks;
  logic [IDXW-1:0] r_cnt;
  logic [LAT-1:0]  r_tag_v;
  logic [LAT-1:0]  r_tag_sel;
  logic [IDXW-1:0] r_tag_idx [LAT];

  logic            w_idle;
  logic            w_issue;
  logic            w_adv;
  logic            w_clk_en;
  logic            w_ack_st;
  logic            w_ack_ks;
  logic [IDXW-1:0] w_last;
  logic            w_out_v;
  logic            w_done;

  // Arbitration, advance and completion decode
  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = (r_state == S_ISSUE);
  assign w_adv    = bus.RandValidxSI & ~w_idle;
  assign w_ack_ks = w_idle & ~RstxRI & bus.KsReqxSI & (~bus.StReqxSI | ~r_last_ks);
  assign w_ack_st = w_idle & ~RstxRI & bus.StReqxSI & ~w_ack_ks;
  assign w_last   = r_sel ? KS_LAST : ST_LAST;
  // A result leaves the last stage only on an advancing cycle, so stalls never duplicate it
  assign w_out_v  = w_adv & r_tag_v[LAT-1];
  assign w_done   = (r_state == S_DRAIN) & w_out_v & (r_tag_idx[LAT-1] == w_last);

`ifdef TI_SBOX_DUMMY_EN
  // Idle cycles still consume masks and clock the S-box with invalid tags
  assign w_clk_en = bus.RandValidxSI;
`else
  assign w_clk_en = w_adv;
`endif

  // FSM, byte counter, arbitration history and tag pipeline
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state   <= S_IDLE;
      r_sel     <= 1'b0;
      r_last_ks <= 1'b0;
      r_cnt     <= '0;
      r_tag_v   <= '0;
      r_tag_sel <= '0;
      for (int i = 0; i < LAT; i++) r_tag_idx[i] <= '0;
    end else begin
      if (w_clk_en) begin
        r_tag_v      <= {r_tag_v[LAT-2:0], w_issue};
        r_tag_sel    <= {r_tag_sel[LAT-2:0], r_sel};
        r_tag_idx[0] <= r_cnt;
        for (int i = 1; i < LAT; i++) r_tag_idx[i] <= r_tag_idx[i-1];
      end
      case (r_state)
        S_IDLE: begin
          if (w_ack_st | w_ack_ks) begin
            r_sel     <= w_ack_ks;
            r_last_ks <= w_ack_ks;
            r_cnt     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_adv) begin
            if (r_cnt == w_last) r_state <= S_DRAIN;
            else                 r_cnt   <= r_cnt + IDXW'(1);
          end
        end
        S_DRAIN: begin
          if (w_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control outputs follow the mask-availability handshake within the cycle
  assign bus.StAckxSO    = w_ack_st;
  assign bus.KsAckxSO    = w_ack_ks;
  assign bus.RandReqxSO  = w_clk_en;
  assign bus.StageEnxSO  = {LAT{w_clk_en}};
  assign bus.InSelxSO    = w_issue & r_sel;
  assign bus.InIdxxDO    = w_issue ? r_cnt : '0;
  assign bus.InValidxSO  = w_issue & w_adv;
  assign bus.OutValidxSO = w_out_v;
  assign bus.OutSelxSO   = w_out_v & r_tag_sel[LAT-1];
  assign bus.OutIdxxDO   = w_out_v ? r_tag_idx[LAT-1] : '0;
  assign bus.StDonexSO   = w_done & ~r_sel;
  assign bus.KsDonexSO   = w_done & r_sel;
  assign bus.BusyxSO     = ~w_idle;

endmodule
